// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage defines: stop/enable constants, reset vector, group stride,
// fetch FSM encoding and address helpers.
package fetch_ctrl_pkg;

    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam logic [31:0] RESET_PC_DEF     = 32'hbfc00000;
    localparam logic [31:0] FETCH_STRIDE_DEF = 32'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        CANCEL = 2'd3
    } fetch_state_e;

    // Redirect targets are word aligned.
    function automatic logic [31:0] align_target(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Next sequential group: realign to the 8-byte group, then advance (wraps mod 2^32).
    function automatic logic [31:0] next_group(input logic [31:0] addr, input logic [31:0] stride);
        return {addr[31:3], 3'b000} + stride;
    endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_latch.sv
// Holds a pending redirect (flush or branch) across an outstanding icache request;
// flush wins over branch and a newer redirect replaces an older pending one.
module redirect_latch
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] epc,
    input  logic        br_redirect,
    input  logic [31:0] npc_actual,
    input  logic        capture,
    input  logic        clear,
    output logic        redir_now,
    output logic [31:0] redir_target,
    output logic        eff_valid,
    output logic [31:0] eff_target
);

    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    // Current-cycle redirect with flush priority.
    always_comb begin
        redir_now = flush | br_redirect;
        if (flush) begin
            redir_target = align_target(epc);
        end else begin
            redir_target = align_target(npc_actual);
        end
    end

    // Pending slot update: clearing on consume beats a fresh capture.
    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (clear) begin
            pend_valid_d = 1'b0;
        end else if (capture && redir_now) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redir_target;
        end else begin
            pend_valid_d  = pend_valid_q;
        end
    end

    // Effective redirect view: a same-cycle redirect overrides the stored one.
    always_comb begin
        eff_valid = redir_now | pend_valid_q;
        if (redir_now) begin
            eff_target = redir_target;
        end else begin
            eff_target = pend_target_q;
        end
    end

    // Pending redirect storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0000_0000;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding icache request, redirect cancel
// handling and dual-issue group delivery to the instruction buffer.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
    parameter logic [31:0] FETCH_STRIDE = FETCH_STRIDE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  stall,
    input  logic        flush,
    input  logic [31:0] epc,
    input  logic        br_redirect,
    input  logic [31:0] npc_actual,
    input  logic        ibuffer_full,
    output logic        rreq_to_icache,
    output logic [31:0] icache_addr,
    input  logic        icache_addr_ok,
    input  logic        icache_data_ok,
    output logic [31:0] pc,
    output logic        group_valid,
    output logic [31:0] group_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         init_q, init_d;
    logic         go_s;
    logic         capture_s, clear_s, keep_s;
    logic         redir_now_s, eff_valid_s;
    logic [31:0]  redir_target_s, eff_target_s;
    logic         unused_stall_s;

    assign unused_stall_s = ^stall[3:1];

    redirect_latch u_redirect_latch (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .epc          (epc),
        .br_redirect  (br_redirect),
        .npc_actual   (npc_actual),
        .capture      (capture_s),
        .clear        (clear_s),
        .redir_now    (redir_now_s),
        .redir_target (redir_target_s),
        .eff_valid    (eff_valid_s),
        .eff_target   (eff_target_s)
    );

    // init_q gates the first request one edge after reset release; stale data_ok is ignored meanwhile.
    always_comb begin
        init_d = 1'b1;
        go_s   = init_q && !ibuffer_full && (stall[0] != Stop);
    end

    // State and pc registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            init_q  <= init_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = go_s ? REQ : IDLE;
            end
            REQ: begin
                if (icache_addr_ok) begin
                    state_d = eff_valid_s ? CANCEL : WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (icache_data_ok) begin
                    state_d = go_s ? REQ : IDLE;
                end else if (redir_now_s) begin
                    state_d = CANCEL;
                end else begin
                    state_d = WAIT;
                end
            end
            CANCEL: begin
                if (icache_data_ok) begin
                    state_d = go_s ? REQ : IDLE;
                end else begin
                    state_d = CANCEL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // pc update, redirect capture/consume and group keep decision.
    always_comb begin
        pc_d      = pc_q;
        capture_s = 1'b0;
        clear_s   = 1'b0;
        keep_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (redir_now_s) begin
                    pc_d    = redir_target_s;
                    clear_s = 1'b1;
                end else begin
                    pc_d = pc_q;
                end
            end
            REQ: begin
                capture_s = redir_now_s;
            end
            WAIT: begin
                if (icache_data_ok && redir_now_s) begin
                    pc_d    = redir_target_s;
                    clear_s = 1'b1;
                end else if (icache_data_ok) begin
                    keep_s = 1'b1;
                    pc_d   = next_group(pc_q, FETCH_STRIDE);
                end else begin
                    capture_s = redir_now_s;
                end
            end
            CANCEL: begin
                if (icache_data_ok) begin
                    pc_d    = eff_target_s;
                    clear_s = 1'b1;
                end else begin
                    capture_s = redir_now_s;
                end
            end
            default: pc_d = RESET_PC;
        endcase
    end

    // Output decode.
    always_comb begin
        rreq_to_icache = (state_q == REQ);
        icache_addr    = pc_q;
        pc             = pc_q;
        group_valid    = keep_s;
        if (keep_s) begin
            group_pc = pc_q;
        end else begin
            group_pc = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, flush/branch cancel, ibuffer
// back-pressure, address wrap and mid-request reset.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  stall;
    logic        flush;
    logic [31:0] epc;
    logic        br_redirect;
    logic [31:0] npc_actual;
    logic        ibuffer_full;
    logic        rreq_to_icache;
    logic [31:0] icache_addr;
    logic        icache_addr_ok;
    logic        icache_data_ok;
    logic [31:0] pc;
    logic        group_valid;
    logic [31:0] group_pc;

    int checks;
    int failures;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .epc            (epc),
        .br_redirect    (br_redirect),
        .npc_actual     (npc_actual),
        .ibuffer_full   (ibuffer_full),
        .rreq_to_icache (rreq_to_icache),
        .icache_addr    (icache_addr),
        .icache_addr_ok (icache_addr_ok),
        .icache_data_ok (icache_data_ok),
        .pc             (pc),
        .group_valid    (group_valid),
        .group_pc       (group_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic a_ok, input logic d_ok, input logic fl, input logic [31:0] e,
                          input logic br, input logic [31:0] n, input logic full);
        icache_addr_ok = a_ok;
        icache_data_ok = d_ok;
        flush          = fl;
        epc            = e;
        br_redirect    = br;
        npc_actual     = n;
        ibuffer_full   = full;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        stall    = 4'b0000;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        nxt(); #1;
        check_eq("rst_rreq", {31'b0, rreq_to_icache}, 32'h0);
        check_eq("rst_pc", pc, 32'hbfc00000);
        check_eq("rst_gv", {31'b0, group_valid}, 32'h0);
        check_eq("rst_gpc", group_pc, 32'h0);

        // Sequential fetch with immediate accept and return.
        nxt(); rst = 1'b1; set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("rel_c0_rreq", {31'b0, rreq_to_icache}, 32'h0);
        nxt(); #1;
        check_eq("rel_c1_rreq", {31'b0, rreq_to_icache}, 32'h0);
        nxt(); #1;
        check_eq("seq0_rreq", {31'b0, rreq_to_icache}, 32'h1);
        check_eq("seq0_addr", icache_addr, 32'hbfc00000);
        nxt(); #1;
        check_eq("seq0_gv", {31'b0, group_valid}, 32'h1);
        check_eq("seq0_gpc", group_pc, 32'hbfc00000);
        nxt(); #1;
        check_eq("seq1_addr", icache_addr, 32'hbfc00008);
        nxt(); #1;
        check_eq("seq1_gv", {31'b0, group_valid}, 32'h1);
        nxt(); #1;
        check_eq("seq2_addr", icache_addr, 32'hbfc00010);
        nxt(); #1;
        check_eq("seq2_gv", {31'b0, group_valid}, 32'h1);
        check_eq("seq2_gpc", group_pc, 32'hbfc00010);

        // Flush during WAIT, data two cycles later; epc low bits masked.
        nxt(); set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("seq3_addr", icache_addr, 32'hbfc00018);
        nxt(); set_in(1'b0, 1'b0, 1'b1, 32'h80000183, 1'b0, 32'h0, 1'b0); #1;
        check_eq("fl_wait_gv", {31'b0, group_valid}, 32'h0);
        nxt(); set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("fl_cancel_rreq", {31'b0, rreq_to_icache}, 32'h0);
        nxt(); set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("fl_drop_gv", {31'b0, group_valid}, 32'h0);
        nxt(); set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("fl_rreq", {31'b0, rreq_to_icache}, 32'h1);
        check_eq("fl_addr", icache_addr, 32'h80000180);

        // Branch redirect together with data_ok.
        nxt(); set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h9000000c, 1'b0); #1;
        check_eq("br_drop_gv", {31'b0, group_valid}, 32'h0);
        nxt(); set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("br_addr", icache_addr, 32'h9000000c);
        nxt(); set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("br_gv", {31'b0, group_valid}, 32'h1);
        check_eq("br_gpc", group_pc, 32'h9000000c);

        // Flush and branch together in REQ, accept three cycles later.
        nxt(); set_in(1'b0, 1'b0, 1'b1, 32'h80000200, 1'b1, 32'h90001000, 1'b0); #1;
        check_eq("req_rd_rreq", {31'b0, rreq_to_icache}, 32'h1);
        check_eq("req_rd_addr0", icache_addr, 32'h90000010);
        nxt(); set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("req_rd_addr1", icache_addr, 32'h90000010);
        nxt(); #1;
        check_eq("req_rd_addr2", icache_addr, 32'h90000010);
        nxt(); set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("req_rd_addr3", icache_addr, 32'h90000010);
        nxt(); set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("req_rd_drop_gv", {31'b0, group_valid}, 32'h0);
        nxt(); set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("req_rd_epc_addr", icache_addr, 32'h80000200);

        // ibuffer back-pressure after a return.
        nxt(); set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); #1;
        check_eq("full_gv", {31'b0, group_valid}, 32'h1);
        check_eq("full_gpc", group_pc, 32'h80000200);
        nxt(); set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); #1;
        check_eq("full_idle_rreq0", {31'b0, rreq_to_icache}, 32'h0);
        check_eq("full_idle_pc", pc, 32'h80000208);
        nxt(); #1;
        check_eq("full_idle_rreq1", {31'b0, rreq_to_icache}, 32'h0);
        nxt(); set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("full_drop_rreq", {31'b0, rreq_to_icache}, 32'h0);
        nxt(); set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("full_resume_rreq", {31'b0, rreq_to_icache}, 32'h1);
        check_eq("full_resume_addr", icache_addr, 32'h80000208);

        // Wrap at the top of the address space.
        nxt(); set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hfffffffb, 1'b0); #1;
        check_eq("wrap_br_gv", {31'b0, group_valid}, 32'h0);
        nxt(); set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("wrap_addr0", icache_addr, 32'hfffffff8);
        nxt(); set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("wrap_gpc", group_pc, 32'hfffffff8);
        nxt(); set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("wrap_addr1", icache_addr, 32'h00000000);
        check_eq("wrap_pc", pc, 32'h00000000);

        // Reset mid-WAIT, stale data_ok right after release.
        nxt(); set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        rst = 1'b0; #1;
        check_eq("mrst_pc", pc, 32'hbfc00000);
        check_eq("mrst_rreq", {31'b0, rreq_to_icache}, 32'h0);
        nxt(); rst = 1'b1; set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("mrst_stale_gv", {31'b0, group_valid}, 32'h0);
        check_eq("mrst_stale_rreq", {31'b0, rreq_to_icache}, 32'h0);
        nxt(); set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check_eq("mrst_c1_rreq", {31'b0, rreq_to_icache}, 32'h0);
        check_eq("mrst_c1_gv", {31'b0, group_valid}, 32'h0);
        nxt(); #1;
        check_eq("mrst_req_rreq", {31'b0, rreq_to_icache}, 32'h1);
        check_eq("mrst_req_addr", icache_addr, 32'hbfc00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
